// File: rtl/router_pkg.sv
// Shared types and defaults for the parametrised router control FSM.
package router_pkg;

    localparam int unsigned DEF_NUM_CH = 3;
    localparam int unsigned DEF_ADDR_W = 2;

    typedef enum logic [3:0] {
        DECODE          = 4'd0,
        LOAD_FIRST      = 4'd1,
        LOAD_DATA       = 4'd2,
        FIFO_FULL       = 4'd3,
        LOAD_AFTER_FULL = 4'd4,
        LOAD_PARITY     = 4'd5,
        CHECK_PARITY    = 4'd6,
        WAIT_EMPTY      = 4'd7,
        DROP            = 4'd8
    } state_e;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/router_wait_timer.sv
// Wait-till-empty timer: clearable, enabled counter with terminal-count flag.
module router_wait_timer #(
    parameter int unsigned WAIT_TIMEOUT = 64,
    parameter int unsigned TMR_W        = 7
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [TMR_W-1:0] cnt_q, cnt_d;

    assign tc = (cnt_q == TMR_W'(WAIT_TIMEOUT - 1));

    // Counter parks at terminal count; the FSM leaves WAIT_EMPTY there anyway.
    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (en && !tc)
            cnt_d = cnt_q + TMR_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/router_ctrl_fsm_n.sv
// Router control FSM for NUM_CH channels: header decode, load, full stall,
// parity, bounded wait-till-empty and drop of unroutable packets.
module router_ctrl_fsm_n
    import router_pkg::*;
#(
    parameter int unsigned NUM_CH       = DEF_NUM_CH,
    parameter int unsigned ADDR_W       = DEF_ADDR_W,
    parameter int unsigned WAIT_TIMEOUT = 64,
    parameter int unsigned TMR_W        = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pkt_vld,
    input  logic [ADDR_W-1:0] din,
    input  logic [NUM_CH-1:0] empty,
    input  logic [NUM_CH-1:0] soft_rst,
    input  logic              fifo_full,
    input  logic              low_pkt_vld,
    input  logic              parity_done,
    output logic              detect_add,
    output logic              lfd,
    output logic              ld,
    output logic              laf,
    output logic              full,
    output logic              write_enb_reg,
    output logic              rst_int_reg,
    output logic              busy,
    output logic              drop,
    output logic [NUM_CH-1:0] sel_ch,
    output logic              timeout_err
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] dest_q, dest_d;
    logic              tmr_tc;
    logic              detect_add_d, lfd_d, ld_d, laf_d, full_d;
    logic              write_enb_reg_d, rst_int_reg_d, busy_d, drop_d;
    logic              timeout_err_d;
    logic [NUM_CH-1:0] sel_ch_d;

    // Out-of-range indices (unroutable header) read as 0 rather than X.
    function automatic logic pick(input logic [NUM_CH-1:0] v, input logic [ADDR_W-1:0] idx);
        logic r;
        r = 1'b0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (32'(idx) == i) r = v[i];
        end
        return r;
    endfunction

    function automatic logic [NUM_CH-1:0] onehot(input logic [ADDR_W-1:0] idx);
        logic [NUM_CH-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (32'(idx) == i) r[i] = 1'b1;
        end
        return r;
    endfunction

    router_wait_timer #(
        .WAIT_TIMEOUT (WAIT_TIMEOUT),
        .TMR_W        (TMR_W)
    ) u_wait_timer (
        .clk (clk),
        .rst (rst),
        .clr (state_q != WAIT_EMPTY),
        .en  (state_q == WAIT_EMPTY),
        .tc  (tmr_tc)
    );

    always_comb begin
        state_d = state_q;
        dest_d  = dest_q;
        case (state_q)
            DECODE: begin
                if (pkt_vld) begin
                    dest_d = din;
                    if (32'(din) >= NUM_CH)
                        state_d = DROP;
                    else if (pick(empty, din))
                        state_d = LOAD_FIRST;
                    else
                        state_d = WAIT_EMPTY;
                end
            end
            LOAD_FIRST:   state_d = LOAD_DATA;
            LOAD_DATA: begin
                if (fifo_full && pkt_vld)
                    state_d = FIFO_FULL;
                else if (!fifo_full && !pkt_vld)
                    state_d = LOAD_PARITY;
            end
            FIFO_FULL: begin
                if (!fifo_full) state_d = LOAD_AFTER_FULL;
            end
            LOAD_AFTER_FULL: begin
                if (parity_done)
                    state_d = DECODE;
                else if (low_pkt_vld)
                    state_d = LOAD_PARITY;
                else
                    state_d = LOAD_DATA;
            end
            LOAD_PARITY:  state_d = CHECK_PARITY;
            CHECK_PARITY: state_d = fifo_full ? FIFO_FULL : DECODE;
            WAIT_EMPTY: begin
                if (pick(empty, dest_q))
                    state_d = LOAD_FIRST;
                else if (tmr_tc)
                    state_d = DROP;
            end
            DROP: begin
                if (!pkt_vld) state_d = DECODE;
            end
            default:      state_d = DECODE;
        endcase
        if (state_q != DECODE && pick(soft_rst, dest_q))
            state_d = DECODE;
    end

    // Outputs are registered from the next state so they stay a pure
    // function of the state register while coming straight off flops.
    always_comb begin
        detect_add_d    = (state_d == DECODE);
        lfd_d           = (state_d == LOAD_FIRST);
        ld_d            = (state_d == LOAD_DATA);
        laf_d           = (state_d == LOAD_AFTER_FULL);
        full_d          = (state_d == FIFO_FULL);
        write_enb_reg_d = (state_d == LOAD_DATA) || (state_d == LOAD_PARITY)
                       || (state_d == LOAD_AFTER_FULL);
        rst_int_reg_d   = (state_d == CHECK_PARITY);
        busy_d          = !((state_d == DECODE) || (state_d == LOAD_DATA) || (state_d == DROP));
        drop_d          = (state_d == DROP);
        sel_ch_d        = (state_d == DECODE) ? '0 : onehot(dest_d);
        timeout_err_d   = (state_q == WAIT_EMPTY) && (state_d == DROP);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= DECODE;
            dest_q        <= '0;
            detect_add    <= 1'b1;
            lfd           <= 1'b0;
            ld            <= 1'b0;
            laf           <= 1'b0;
            full          <= 1'b0;
            write_enb_reg <= 1'b0;
            rst_int_reg   <= 1'b0;
            busy          <= 1'b0;
            drop          <= 1'b0;
            sel_ch        <= '0;
            timeout_err   <= 1'b0;
        end else begin
            state_q       <= state_d;
            dest_q        <= dest_d;
            detect_add    <= detect_add_d;
            lfd           <= lfd_d;
            ld            <= ld_d;
            laf           <= laf_d;
            full          <= full_d;
            write_enb_reg <= write_enb_reg_d;
            rst_int_reg   <= rst_int_reg_d;
            busy          <= busy_d;
            drop          <= drop_d;
            sel_ch        <= sel_ch_d;
            timeout_err   <= timeout_err_d;
        end
    end

endmodule

// File: tb/tb_router_ctrl_fsm_n.sv
// Scoreboard bench for router_ctrl_fsm_n (NUM_CH=3, ADDR_W=2, WAIT_TIMEOUT=64).
module tb_router_ctrl_fsm_n;

    localparam int unsigned NUM_CH       = 3;
    localparam int unsigned ADDR_W       = 2;
    localparam int unsigned WAIT_TIMEOUT = 64;
    localparam int unsigned TMR_W        = 7;

    logic              clk = 1'b0;
    logic              rst;
    logic              pkt_vld;
    logic [ADDR_W-1:0] din;
    logic [NUM_CH-1:0] empty;
    logic [NUM_CH-1:0] soft_rst;
    logic              fifo_full;
    logic              low_pkt_vld;
    logic              parity_done;
    logic              detect_add, lfd, ld, laf, full, write_enb_reg, rst_int_reg;
    logic              busy, drop, timeout_err;
    logic [NUM_CH-1:0] sel_ch;

    router_ctrl_fsm_n #(
        .NUM_CH       (NUM_CH),
        .ADDR_W       (ADDR_W),
        .WAIT_TIMEOUT (WAIT_TIMEOUT),
        .TMR_W        (TMR_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .pkt_vld       (pkt_vld),
        .din           (din),
        .empty         (empty),
        .soft_rst      (soft_rst),
        .fifo_full     (fifo_full),
        .low_pkt_vld   (low_pkt_vld),
        .parity_done   (parity_done),
        .detect_add    (detect_add),
        .lfd           (lfd),
        .ld            (ld),
        .laf           (laf),
        .full          (full),
        .write_enb_reg (write_enb_reg),
        .rst_int_reg   (rst_int_reg),
        .busy          (busy),
        .drop          (drop),
        .sel_ch        (sel_ch),
        .timeout_err   (timeout_err)
    );

    always #5 clk = ~clk;

    typedef enum {S_DEC, S_LFD, S_LD, S_FF, S_LAF, S_LP, S_CP, S_WAIT, S_DROP} tst_e;

    typedef struct {
        string       name;
        logic [12:0] v;
    } exp_t;

    typedef struct {
        logic        pv;
        logic [1:0]  d;
        logic [2:0]  emp;
        logic        ff;
        logic        lpv;
        logic        pd;
        logic [2:0]  sr;
        tst_e        s;
        logic [2:0]  sel;
        logic        terr;
    } stim_t;

    exp_t        sb[$];
    exp_t        e;
    exp_t        x;
    int          checks   = 0;
    int          failures = 0;
    logic [12:0] obs;

    assign obs = {detect_add, lfd, ld, laf, full, write_enb_reg, rst_int_reg,
                  busy, drop, timeout_err, sel_ch};

    // Expected output vector for a given state, built from the output table.
    function automatic logic [12:0] mk(input tst_e s, input logic [2:0] sel, input logic terr);
        logic b;
        b = !(s == S_DEC || s == S_LD || s == S_DROP);
        return {s == S_DEC, s == S_LFD, s == S_LD, s == S_LAF, s == S_FF,
                (s == S_LD || s == S_LP || s == S_LAF), s == S_CP,
                b, s == S_DROP, terr, sel};
    endfunction

    function automatic stim_t st(input logic pv, input logic [1:0] d, input logic [2:0] emp,
                                 input logic ff, input logic lpv, input logic pd,
                                 input logic [2:0] sr, input tst_e s, input logic [2:0] sel,
                                 input logic terr);
        stim_t r;
        r.pv = pv; r.d = d; r.emp = emp; r.ff = ff; r.lpv = lpv; r.pd = pd;
        r.sr = sr; r.s = s; r.sel = sel; r.terr = terr;
        return r;
    endfunction

    task automatic apply(input stim_t t);
        pkt_vld     = t.pv;
        din         = t.d;
        empty       = t.emp;
        fifo_full   = t.ff;
        low_pkt_vld = t.lpv;
        parity_done = t.pd;
        soft_rst    = t.sr;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        apply(st(0, 0, 3'b111, 0, 0, 0, 3'b000, S_DEC, 3'b000, 0));
        repeat (2) @(posedge clk);
        #1;
        x.name = "reset_hold"; x.v = mk(S_DEC, 3'b000, 1'b0); sb.push_back(x);
        e = sb.pop_front(); checks++;
        if (obs !== e.v) begin
            failures++;
            $display("FAIL %s: got=%b required=%b", e.name, obs, e.v);
        end
        rst = 1'b0;
        x.name = "reset_idle"; x.v = mk(S_DEC, 3'b000, 1'b0); sb.push_back(x);
        @(posedge clk); #1;
        e = sb.pop_front(); checks++;
        if (obs !== e.v) begin
            failures++;
            $display("FAIL %s: got=%b required=%b", e.name, obs, e.v);
        end
    endtask

    task automatic test_normal_packet();
        stim_t t[$];
        t.push_back(st(1, 2, 3'b111, 0, 0, 0, 3'b000, S_LFD, 3'b100, 0));
        for (int i = 0; i < 4; i++)
            t.push_back(st(1, 2'(i), 3'b111, 0, 0, 0, 3'b000, S_LD, 3'b100, 0));
        t.push_back(st(0, 1, 3'b111, 0, 0, 0, 3'b000, S_LP, 3'b100, 0));
        t.push_back(st(0, 0, 3'b111, 0, 0, 0, 3'b000, S_CP, 3'b100, 0));
        t.push_back(st(0, 0, 3'b111, 0, 0, 0, 3'b000, S_DEC, 3'b000, 0));
        foreach (t[i]) begin
            apply(t[i]);
            x.name = "normal_packet"; x.v = mk(t[i].s, t[i].sel, t[i].terr); sb.push_back(x);
            @(posedge clk); #1;
            e = sb.pop_front(); checks++;
            if (obs !== e.v) begin
                failures++;
                $display("FAIL %s step %0d: got=%b required=%b", e.name, i, obs, e.v);
            end
        end
    endtask

    task automatic test_bad_addr_drop();
        stim_t t[$];
        t.push_back(st(1, 3, 3'b111, 0, 0, 0, 3'b000, S_DROP, 3'b000, 0));
        t.push_back(st(1, 0, 3'b111, 0, 0, 0, 3'b000, S_DROP, 3'b000, 0));
        t.push_back(st(1, 1, 3'b111, 1, 0, 0, 3'b000, S_DROP, 3'b000, 0));
        t.push_back(st(0, 0, 3'b111, 0, 0, 0, 3'b000, S_DEC, 3'b000, 0));
        foreach (t[i]) begin
            apply(t[i]);
            x.name = "bad_addr_drop"; x.v = mk(t[i].s, t[i].sel, t[i].terr); sb.push_back(x);
            @(posedge clk); #1;
            e = sb.pop_front(); checks++;
            if (obs !== e.v) begin
                failures++;
                $display("FAIL %s step %0d: got=%b required=%b", e.name, i, obs, e.v);
            end
        end
    endtask

    // release_last=1 raises empty[1] in the final WAIT_EMPTY cycle (timer at limit).
    task automatic test_wait_timeout(input logic release_last);
        stim_t t[$];
        t.push_back(st(1, 1, 3'b101, 0, 0, 0, 3'b000, S_WAIT, 3'b010, 0));
        for (int i = 1; i < int'(WAIT_TIMEOUT); i++)
            t.push_back(st(0, 0, 3'b101, 0, 0, 0, 3'b000, S_WAIT, 3'b010, 0));
        if (!release_last) begin
            t.push_back(st(0, 0, 3'b101, 0, 0, 0, 3'b000, S_DROP, 3'b010, 1));
            t.push_back(st(1, 0, 3'b101, 0, 0, 0, 3'b000, S_DROP, 3'b010, 0));
            t.push_back(st(0, 0, 3'b101, 0, 0, 0, 3'b000, S_DEC, 3'b000, 0));
        end else begin
            t.push_back(st(1, 0, 3'b111, 0, 0, 0, 3'b000, S_LFD, 3'b010, 0));
            t.push_back(st(1, 0, 3'b111, 0, 0, 0, 3'b000, S_LD, 3'b010, 0));
            t.push_back(st(0, 0, 3'b111, 0, 0, 0, 3'b000, S_LP, 3'b010, 0));
            t.push_back(st(0, 0, 3'b111, 0, 0, 0, 3'b000, S_CP, 3'b010, 0));
            t.push_back(st(0, 0, 3'b111, 0, 0, 0, 3'b000, S_DEC, 3'b000, 0));
        end
        foreach (t[i]) begin
            apply(t[i]);
            x.name = release_last ? "wait_release" : "wait_timeout";
            x.v = mk(t[i].s, t[i].sel, t[i].terr);
            sb.push_back(x);
            @(posedge clk); #1;
            e = sb.pop_front(); checks++;
            if (obs !== e.v) begin
                failures++;
                $display("FAIL %s step %0d: got=%b required=%b", e.name, i, obs, e.v);
            end
        end
    endtask

    task automatic test_fifo_full();
        stim_t t[$];
        t.push_back(st(1, 0, 3'b111, 0, 0, 0, 3'b000, S_LFD, 3'b001, 0));
        t.push_back(st(1, 0, 3'b111, 0, 0, 0, 3'b000, S_LD, 3'b001, 0));
        t.push_back(st(1, 0, 3'b111, 1, 0, 0, 3'b000, S_FF, 3'b001, 0));
        t.push_back(st(1, 0, 3'b111, 1, 0, 0, 3'b000, S_FF, 3'b001, 0));
        t.push_back(st(0, 0, 3'b111, 0, 1, 0, 3'b000, S_LAF, 3'b001, 0));
        t.push_back(st(0, 0, 3'b111, 0, 1, 0, 3'b000, S_LP, 3'b001, 0));
        t.push_back(st(0, 0, 3'b111, 0, 0, 0, 3'b000, S_CP, 3'b001, 0));
        t.push_back(st(0, 0, 3'b111, 1, 0, 0, 3'b000, S_FF, 3'b001, 0));
        t.push_back(st(0, 0, 3'b111, 0, 0, 0, 3'b000, S_LAF, 3'b001, 0));
        t.push_back(st(0, 0, 3'b111, 0, 0, 0, 3'b000, S_LD, 3'b001, 0));
        t.push_back(st(1, 0, 3'b111, 1, 0, 0, 3'b000, S_FF, 3'b001, 0));
        t.push_back(st(0, 0, 3'b111, 0, 1, 1, 3'b000, S_LAF, 3'b001, 0));
        t.push_back(st(0, 0, 3'b111, 0, 1, 1, 3'b000, S_DEC, 3'b000, 0));
        foreach (t[i]) begin
            apply(t[i]);
            x.name = "fifo_full"; x.v = mk(t[i].s, t[i].sel, t[i].terr); sb.push_back(x);
            @(posedge clk); #1;
            e = sb.pop_front(); checks++;
            if (obs !== e.v) begin
                failures++;
                $display("FAIL %s step %0d: got=%b required=%b", e.name, i, obs, e.v);
            end
        end
    endtask

    task automatic test_soft_reset();
        stim_t t[$];
        t.push_back(st(1, 0, 3'b111, 0, 0, 0, 3'b001, S_LFD, 3'b001, 0));
        t.push_back(st(1, 0, 3'b111, 0, 0, 0, 3'b000, S_LD, 3'b001, 0));
        t.push_back(st(1, 0, 3'b111, 0, 0, 0, 3'b010, S_LD, 3'b001, 0));
        t.push_back(st(1, 1, 3'b111, 0, 0, 0, 3'b010, S_LD, 3'b001, 0));
        t.push_back(st(1, 1, 3'b111, 0, 0, 0, 3'b001, S_DEC, 3'b000, 0));
        t.push_back(st(0, 0, 3'b111, 0, 0, 0, 3'b000, S_DEC, 3'b000, 0));
        foreach (t[i]) begin
            apply(t[i]);
            x.name = "soft_reset"; x.v = mk(t[i].s, t[i].sel, t[i].terr); sb.push_back(x);
            @(posedge clk); #1;
            e = sb.pop_front(); checks++;
            if (obs !== e.v) begin
                failures++;
                $display("FAIL %s step %0d: got=%b required=%b", e.name, i, obs, e.v);
            end
        end
    endtask

    task automatic test_async_reset();
        stim_t t[$];
        t.push_back(st(1, 2, 3'b111, 0, 0, 0, 3'b000, S_LFD, 3'b100, 0));
        t.push_back(st(1, 2, 3'b111, 0, 0, 0, 3'b000, S_LD, 3'b100, 0));
        foreach (t[i]) begin
            apply(t[i]);
            x.name = "async_setup"; x.v = mk(t[i].s, t[i].sel, t[i].terr); sb.push_back(x);
            @(posedge clk); #1;
            e = sb.pop_front(); checks++;
            if (obs !== e.v) begin
                failures++;
                $display("FAIL %s step %0d: got=%b required=%b", e.name, i, obs, e.v);
            end
        end
        // Mid-cycle, well before the next rising edge.
        #2;
        rst = 1'b1;
        x.name = "async_reset"; x.v = mk(S_DEC, 3'b000, 1'b0); sb.push_back(x);
        #1;
        e = sb.pop_front(); checks++;
        if (obs !== e.v) begin
            failures++;
            $display("FAIL %s: got=%b required=%b", e.name, obs, e.v);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        apply(st(0, 0, 3'b111, 0, 0, 0, 3'b000, S_DEC, 3'b000, 0));
        x.name = "after_async_reset"; x.v = mk(S_DEC, 3'b000, 1'b0); sb.push_back(x);
        @(posedge clk); #1;
        e = sb.pop_front(); checks++;
        if (obs !== e.v) begin
            failures++;
            $display("FAIL %s: got=%b required=%b", e.name, obs, e.v);
        end
    endtask

    initial begin
        test_reset();
        test_normal_packet();
        test_bad_addr_drop();
        test_wait_timeout(1'b0);
        test_wait_timeout(1'b1);
        test_fifo_full();
        test_soft_reset();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/router_ctrl_fsm_n.md
Name: router_ctrl_fsm_n

Overview:
Parametrised successor of the 1x3 router control FSM. It sequences header decode, payload load, FIFO-full stall, parity load and parity check for a router with NUM_CH output channels.
- Adds a latched destination and per-channel soft reset.
- Adds a bounded wait-till-empty with timeout.
- Adds a DROP state that discards packets addressed to a nonexistent channel or whose wait timed out.
- Sits between the router register block and the per-channel FIFO/sync block.

Parameters:
NUM_CH, 3, number of output channels (2..16)
ADDR_W, 2, header address field width; must satisfy 2**ADDR_W >= NUM_CH
WAIT_TIMEOUT, 64, cycles allowed in WAIT_EMPTY before the packet is dropped (>=1)
TMR_W, 7, timeout counter width; must satisfy 2**TMR_W > WAIT_TIMEOUT

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
pkt_vld  in  1  packet valid from source
din  in  ADDR_W  header address field (data[ADDR_W-1:0])
empty  in  NUM_CH  per-channel FIFO empty
soft_rst  in  NUM_CH  per-channel soft reset from sync block
fifo_full  in  1  full flag of the selected FIFO
low_pkt_vld  in  1  register block: pkt_vld fell during full
parity_done  in  1  register block: parity byte captured
detect_add  out  1  state==DECODE
lfd  out  1  state==LOAD_FIRST
ld  out  1  state==LOAD_DATA
laf  out  1  state==LOAD_AFTER_FULL
full  out  1  state==FIFO_FULL
write_enb_reg  out  1  LOAD_DATA | LOAD_PARITY | LOAD_AFTER_FULL
rst_int_reg  out  1  state==CHECK_PARITY
busy  out  1  0 in DECODE, LOAD_DATA, DROP; else 1
drop  out  1  state==DROP
sel_ch  out  NUM_CH  one-hot latched destination; 0 in DECODE
timeout_err  out  1  one-cycle pulse on WAIT_EMPTY->DROP

Behaviour:
- Moore machine. All outputs decode from the state register, except timeout_err, which is a registered pulse.
- Reset (async, rst=1): state=DECODE, dest=0, timer=0, timeout_err=0. Reset outputs: detect_add=1, sel_ch=0, everything else 0.
- dest register: loaded with din on every cycle where state==DECODE and pkt_vld=1. It holds its value until the machine returns to DECODE. All later empty/soft_rst checks use dest, never the live din.
- DECODE:
  - pkt_vld=0 -> DECODE.
  - pkt_vld=1 and din>=NUM_CH -> DROP.
  - pkt_vld=1, valid address, empty[din]=1 -> LOAD_FIRST.
  - pkt_vld=1, valid address, empty[din]=0 -> WAIT_EMPTY, timer cleared.
- LOAD_FIRST -> LOAD_DATA, unconditionally.
- LOAD_DATA:
  - fifo_full=1 and pkt_vld=1 -> FIFO_FULL.
  - fifo_full=0 and pkt_vld=0 -> LOAD_PARITY.
  - otherwise stay in LOAD_DATA.
- FIFO_FULL: fifo_full=0 -> LOAD_AFTER_FULL; otherwise stay.
- LOAD_AFTER_FULL:
  - parity_done=1 -> DECODE (takes priority).
  - low_pkt_vld=1 -> LOAD_PARITY.
  - otherwise -> LOAD_DATA.
- LOAD_PARITY -> CHECK_PARITY.
- CHECK_PARITY: fifo_full=1 -> FIFO_FULL; otherwise -> DECODE.
- WAIT_EMPTY:
  - Each cycle: if empty[dest]=1 -> LOAD_FIRST.
  - Else if timer==WAIT_TIMEOUT-1 -> DROP, with timeout_err=1 for the next cycle.
  - Else timer increments.
  - If empty[dest] and timeout occur in the same cycle, empty wins.
- DROP: busy=0 and write_enb_reg=0, so source bytes are consumed and discarded. pkt_vld=0 -> DECODE.
- Soft reset: soft_rst[dest]=1 in any state other than DECODE forces DECODE on the next edge, overriding the next-state logic. soft_rst on other channels is ignored. In DECODE, soft_rst has no effect.
- Illegal or unused state encodings -> DECODE.
- Latency: header accepted in DECODE; lfd is asserted exactly one cycle later when the FIFO is empty.

Decomposition:
- Package router_pkg:
  - state enum: DECODE, LOAD_FIRST, LOAD_DATA, FIFO_FULL, LOAD_AFTER_FULL, LOAD_PARITY, CHECK_PARITY, WAIT_EMPTY, DROP (4-bit encoding).
  - clog2 function.
  - Default NUM_CH and ADDR_W constants.
- One sub-module, router_wait_timer: clear/enable counter with a terminal-count flag at WAIT_TIMEOUT-1.

Test Plan:
1. NUM_CH=3, empty=3'b111, header din=2, 4 payload bytes, pkt_vld low on the parity byte -> state sequence DECODE, LOAD_FIRST, LOAD_DATAx4, LOAD_PARITY, CHECK_PARITY, DECODE; sel_ch=3'b100 throughout.
2. din=3 with NUM_CH=3 -> DROP; busy=0, write_enb_reg=0 for the whole packet; DECODE the cycle after pkt_vld falls.
3. empty[1]=0, din=1, WAIT_TIMEOUT=64, empty stays 0 -> timeout_err pulses once 64 cycles after entering WAIT_EMPTY, then DROP. Repeat with empty[1] rising at cycle 63 -> LOAD_FIRST and no timeout_err.
4. fifo_full=1 during LOAD_DATA with pkt_vld=1 -> FIFO_FULL, busy=1. Release fifo_full with parity_done=0 and low_pkt_vld=1 -> LOAD_AFTER_FULL, then LOAD_PARITY.
5. In LOAD_DATA for dest=0: soft_rst=3'b010 -> no change; soft_rst=3'b001 -> DECODE next edge, sel_ch=0.
6. Assert rst asynchronously mid-LOAD_DATA -> detect_add=1 and all other outputs 0 immediately, without waiting for a clock edge.
